// File: rtl/gen12_sym_pkg.sv
// Gen1/Gen2 framing symbols, framer state encoding and packet type
// encoding, shared by the transmit framer and the receive-side detector.
package gen12_sym_pkg;

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_IDL = 8'h00;

  localparam logic TYPE_TLP  = 1'b0;
  localparam logic TYPE_DLLP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TAIL    = 2'd2
  } tx_state_t;

  function automatic logic [7:0] sof_sym(input logic t);
    return (t == TYPE_DLLP) ? SYM_SDP : SYM_STP;
  endfunction

  function automatic logic [7:0] term_sym(input logic t,
                                          input logic nullify);
    return (t == TYPE_TLP && nullify) ? SYM_EDB : SYM_END;
  endfunction

endpackage

// File: rtl/gen12_tx_merge.sv
// Combinational beat assembly: {lead, payload, terminator, IDL fill}
// plus next-carry and overflow (tail) symbol selection.
module gen12_tx_merge
  import gen12_sym_pkg::*;
#(
  parameter  int W  = 4,
  localparam int BW = $clog2(W) + 1
) (
  input  logic [7:0]     lead,
  input  logic           lead_k,
  input  logic [8*W-1:0] data,
  input  logic           eop,
  input  logic [BW-1:0]  k,
  input  logic [7:0]     term,
  output logic [8*W-1:0] out_data,
  output logic [W-1:0]   out_dk,
  output logic [7:0]     next_carry,
  output logic [15:0]    tail_data,
  output logic [1:0]     tail_dk,
  output logic           tail_needed
);

  // Symbol slot i of the W+2 slots a beat can produce.
  logic [7:0] seq   [W+2];
  logic       seq_k [W+2];
  int         kk;

  always_comb begin
    kk = int'(k);
    for (int i = 0; i < W + 2; i++) begin
      seq[i]   = SYM_IDL;
      seq_k[i] = 1'b0;
    end
    seq[0]   = lead;
    seq_k[0] = lead_k;
    for (int i = 1; i <= W; i++) begin
      if (i <= kk) seq[i] = data[8*(i-1) +: 8];
    end
    if (eop) begin
      seq[kk+1]   = term;
      seq_k[kk+1] = 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    out_dk   = '0;
    for (int i = 0; i < W; i++) begin
      out_data[8*i +: 8] = seq[i];
      out_dk[i]          = seq_k[i];
    end
  end

  assign next_carry  = data[8*W-1 -: 8];
  assign tail_data   = {seq[W+1], seq[W]};
  assign tail_dk     = {seq_k[W+1], seq_k[W]};
  assign tail_needed = eop && (int'(k) + 2 > W);

endmodule

// File: rtl/gen1_2_tx_framer.sv
// Gen1/Gen2 transmit framer: STP/SDP prepend, END/EDB append, IDL fill.
// Optional per-type frame counters: define GEN12_TX_FRAME_CNT_EN.
module gen1_2_tx_framer
  import gen12_sym_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*W-1:0]        in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_type,
  input  logic [$clog2(W):0]    in_bytes,
  input  logic                  in_nullify,
  output logic [8*W-1:0]        tx_data,
  output logic [W-1:0]          tx_dk,
`ifdef GEN12_TX_FRAME_CNT_EN
  output logic [CNT_W-1:0]      tlp_count,
  output logic [CNT_W-1:0]      dllp_count,
`endif
  output logic                  framing_err
);

  localparam int BW = $clog2(W) + 1;

  tx_state_t   state;
  logic [7:0]  carry;
  logic [15:0] tail_q;
  logic [1:0]  tail_dk_q;
  logic        type_q;

  logic          accept, take, bytes_bad, pkt_type;
  logic [BW-1:0] k_eff;
  logic [7:0]    lead, term;

  logic [8*W-1:0] m_data;
  logic [W-1:0]   m_dk;
  logic [7:0]     m_carry;
  logic [15:0]    m_tail;
  logic [1:0]     m_tail_dk;
  logic           m_tail_need;

  assign in_ready  = reset ? 1'b0 : (state != ST_TAIL);
  assign accept    = in_valid && in_ready;
  // A non-sop beat in IDLE is dropped; anything else accepted is framed.
  assign take      = accept && (state == ST_PAYLOAD || in_sop);
  assign bytes_bad = in_eop && (in_bytes == '0 || int'(in_bytes) > W);
  assign k_eff     = (!in_eop || bytes_bad) ? BW'(W) : in_bytes;
  assign pkt_type  = (state == ST_IDLE) ? in_type : type_q;
  assign lead      = (state == ST_IDLE) ? sof_sym(in_type) : carry;
  assign term      = term_sym(pkt_type, in_nullify);

  gen12_tx_merge #(.W(W)) u_merge (
    .lead        (lead),
    .lead_k      (state == ST_IDLE),
    .data        (in_data),
    .eop         (in_eop),
    .k           (k_eff),
    .term        (term),
    .out_data    (m_data),
    .out_dk      (m_dk),
    .next_carry  (m_carry),
    .tail_data   (m_tail),
    .tail_dk     (m_tail_dk),
    .tail_needed (m_tail_need)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      carry       <= '0;
      tail_q      <= '0;
      tail_dk_q   <= '0;
      type_q      <= TYPE_TLP;
      tx_data     <= '0;
      tx_dk       <= '0;
      framing_err <= 1'b0;
    end else begin
      tx_data     <= '0;
      tx_dk       <= '0;
      framing_err <= accept &&
                     ((state == ST_IDLE && !in_sop) ||
                      (state == ST_PAYLOAD && in_sop) ||
                      (take && bytes_bad));
      case (state)
        ST_IDLE, ST_PAYLOAD: begin
          if (take) begin
            tx_data <= m_data;
            tx_dk   <= m_dk;
            carry   <= m_carry;
            if (state == ST_IDLE) type_q <= in_type;
            if (!in_eop) begin
              state <= ST_PAYLOAD;
            end else if (m_tail_need) begin
              tail_q    <= m_tail;
              tail_dk_q <= m_tail_dk;
              state     <= ST_TAIL;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_TAIL: begin
          tx_data[15:0] <= tail_q;
          tx_dk[1:0]    <= tail_dk_q;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GEN12_TX_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tlp_count  <= '0;
      dllp_count <= '0;
    end else if (take && in_eop) begin
      if (pkt_type == TYPE_TLP) begin
        if (tlp_count != '1) tlp_count <= tlp_count + 1'b1;
      end else begin
        if (dllp_count != '1) dllp_count <= dllp_count + 1'b1;
      end
    end
  end
`endif

endmodule
